rf_write_arbiter: RTL

// - Shares the register file's single write port between two writeback sources: ALU result (req 0) and memory load (req 1).
// - Uses 2-way round-robin arbitration with a valid/ready handshake per source.
// - Registers the granted write in one staging stage, then drives the register file write port (we/addr/data).
// - Exports a pending-write mask for hazard logic and a saturating contention counter for debug.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rf_write_arbiter_if.sv | 26 ++
 rtl/rr_arb2.sv | 36 +++
 rtl/rf_write_arbiter.sv | 93 +++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file writeback types: widths, source IDs and the staged write payload.
package regfile_pkg;

    localparam int unsigned RF_DATA_W = 8;
    localparam int unsigned RF_ADDR_W = 3;
    localparam int unsigned RF_CNT_W  = 8;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    typedef struct packed {
        logic                 we;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback request channels (ALU and memory load) with per-source valid/ready.
interface rf_write_arbiter_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; the pointer moves to the loser after every grant.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       ptr
);
    logic r_ptr;

    // Contention resolved by the pointer; a lone request always wins.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (r_ptr == SRC_MEM) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= SRC_ALU;
        end else if (|gnt) begin
            r_ptr <= gnt[0] ? SRC_MEM : SRC_ALU;
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback through
// a round-robin grant and a single staging register.
module rf_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned CNT_W  = RF_CNT_W
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    rf_write_arbiter_if.slave       wb,
    output logic                    rf_we,
    output logic [ADDR_W-1:0]       rf_waddr,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic [(1<<ADDR_W)-1:0]  pending_mask,
    output logic                    last_grant,
    output logic [CNT_W-1:0]        conflict_cnt
);
    localparam int unsigned NREG = 1 << ADDR_W;

    logic [1:0]        w_gnt;
    logic              w_ptr;
    logic              w_accept;
    logic              w_both;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    rf_wr_t            r_stage;
    logic [NREG-1:0]   r_pend;
    logic              r_last;
    logic [CNT_W-1:0]  r_cnt;

    // Reset also gates the arbiter so nothing is accepted while rst_n is low.
    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({wb.mem_valid, wb.alu_valid}),
        .en    (!stall && rst_n),
        .gnt   (w_gnt),
        .ptr   (w_ptr)
    );

    assign wb.alu_ready = w_gnt[0];
    assign wb.mem_ready = w_gnt[1];
    assign w_accept     = |w_gnt;
    assign w_both       = wb.alu_valid && wb.mem_valid && !stall;
    assign w_sel_addr   = w_gnt[1] ? wb.mem_rd   : wb.alu_rd;
    assign w_sel_data   = w_gnt[1] ? wb.mem_data : wb.alu_data;

    // Staging register: address/data hold their last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
            r_pend  <= '0;
            r_last  <= SRC_ALU;
        end else begin
            r_stage.we <= w_accept;
            r_pend     <= '0;
            if (w_accept) begin
                r_stage.addr       <= RF_ADDR_W'(w_sel_addr);
                r_stage.data       <= RF_DATA_W'(w_sel_data);
                r_pend[w_sel_addr] <= 1'b1;
                r_last             <= w_gnt[1];
            end
        end
    end

    // Saturating count of contended, unstalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_both && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // One cycle after any accept the pointer must name the source that lost.
    always_ff @(posedge clk) begin
        if (rst_n && r_stage.we) begin
            assert (w_ptr != r_last);
        end
    end

    assign rf_we        = r_stage.we;
    assign rf_waddr     = ADDR_W'(r_stage.addr);
    assign rf_wdata     = DATA_W'(r_stage.data);
    assign pending_mask = r_pend;
    assign last_grant   = r_last;
    assign conflict_cnt = r_cnt;

endmodule
